// File: rtl/dma_wb_burst_master_if.sv
// Classic Wishbone master/slave bundle between the burst master and the PCIe SGDMA adapter.
interface dma_wb_burst_master_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] wb_adr_o;
    logic [63:0]       wb_dat_o;
    logic [63:0]       wb_dat_i;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic              wb_lock_o;
    logic [7:0]        wb_sel_o;
    logic              wb_ack_i;
    logic              wb_err_i;
    logic              wb_rty_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_lock_o, wb_sel_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_lock_o, wb_sel_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
endinterface

// File: rtl/dma_wb_burst_master.sv
// Two-channel Wishbone burst master: one descriptor per channel, round-robin grants to the
// SGDMA adapter, bursts capped at MAX_BURST words and never crossing a 4KB page.
module dma_wb_burst_master #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [1:0]        ch_start,
    input  logic [1:0]        ch_write,
    input  logic [ADDR_W-1:0] ch0_addr,
    input  logic [ADDR_W-1:0] ch1_addr,
    input  logic [LEN_W-1:0]  ch0_len,
    input  logic [LEN_W-1:0]  ch1_len,
    output logic [1:0]        ch_busy,
    output logic [1:0]        ch_done,
    output logic [1:0]        ch_err,
    input  logic [1:0]        dma_req,
    output logic [1:0]        dma_ack,
    output logic [1:0]        active_ch,
    output logic [15:0]       burst_len,
    dma_wb_burst_master_if.master wb,
    input  logic [63:0]       src_data,
    input  logic              src_valid,
    output logic              src_rd,
    output logic [63:0]       snk_data,
    output logic              snk_dv
);
    localparam int unsigned WA_W = ADDR_W - 3;
    localparam int unsigned BC_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BURST, S_RETRY} state_t;

    state_t            state_q, state_d;
    logic [WA_W-1:0]   waddr_q [2];
    logic [LEN_W-1:0]  rem_q   [2];
    logic [1:0]        we_q, busy_q, done_q, err_q, dma_ack_q, active_q;
    logic              sel_q, last_q, cyc_q, snk_dv_q;
    logic [BC_W-1:0]   beats_q;
    logic [15:0]       burst_len_q;
    logic [63:0]       snk_data_q;

    logic [WA_W-1:0]   addr_in_c [2];
    logic [LEN_W-1:0]  len_in_c  [2];
    logic [1:0]        elig_c, start_ok_c;
    logic              sel_c, cur_we_c, stb_c, ack_hit_c, err_hit_c, rty_hit_c, last_beat_c;
    logic [9:0]        room_c;
    int unsigned       blen_c;
    logic              unused_addr_bits;

    assign addr_in_c[0] = ch0_addr[ADDR_W-1:3];
    assign addr_in_c[1] = ch1_addr[ADDR_W-1:3];
    assign len_in_c[0]  = ch0_len;
    assign len_in_c[1]  = ch1_len;
    assign unused_addr_bits = ^{ch0_addr[2:0], ch1_addr[2:0]};

    // A start landing on a busy channel, or on the cycle its done/err pulses, is dropped.
    assign start_ok_c  = ch_start & ~busy_q & ~done_q & ~err_q;
    assign elig_c      = busy_q & dma_req;
    assign cur_we_c    = we_q[sel_q];
    assign stb_c       = cyc_q & (cur_we_c ? src_valid : 1'b1);
    assign ack_hit_c   = stb_c & wb.wb_ack_i;
    assign err_hit_c   = stb_c & wb.wb_err_i;
    assign rty_hit_c   = stb_c & wb.wb_rty_i;
    assign last_beat_c = (beats_q == BC_W'(1));

    // Arbitration and burst sizing for the channel that would be granted from IDLE.
    always_comb begin
        sel_c  = elig_c[1];
        if (elig_c == 2'b11) sel_c = ~last_q;
        room_c = 10'd512 - {1'b0, waddr_q[sel_c][8:0]};
        blen_c = 32'(rem_q[sel_c]);
        if (blen_c > MAX_BURST)     blen_c = MAX_BURST;
        if (blen_c > 32'(room_c))   blen_c = 32'(room_c);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (elig_c != 2'b00) state_d = S_GRANT;
            S_GRANT: state_d = S_BURST;
            S_BURST: begin
                if (err_hit_c)                      state_d = S_IDLE;
                else if (ack_hit_c && last_beat_c)  state_d = S_IDLE;
                else if (!ack_hit_c && rty_hit_c)   state_d = S_RETRY;
            end
            S_RETRY: state_d = S_BURST;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < 2; i++) begin
                waddr_q[i] <= '0;
                rem_q[i]   <= '0;
            end
            we_q        <= '0;
            busy_q      <= '0;
            done_q      <= '0;
            err_q       <= '0;
            dma_ack_q   <= '0;
            active_q    <= '0;
            sel_q       <= 1'b0;
            last_q      <= 1'b1;
            cyc_q       <= 1'b0;
            beats_q     <= '0;
            burst_len_q <= '0;
            snk_dv_q    <= 1'b0;
            snk_data_q  <= '0;
        end else begin
            done_q    <= '0;
            err_q     <= '0;
            dma_ack_q <= '0;
            cyc_q     <= (state_d == S_BURST);
            snk_dv_q  <= ack_hit_c & ~cur_we_c;
            if (ack_hit_c && !cur_we_c) snk_data_q <= wb.wb_dat_i;

            for (int i = 0; i < 2; i++) begin
                if (start_ok_c[i]) begin
                    waddr_q[i] <= addr_in_c[i];
                    rem_q[i]   <= len_in_c[i];
                    we_q[i]    <= ch_write[i];
                    if (len_in_c[i] == '0) done_q[i] <= 1'b1;
                    else                   busy_q[i] <= 1'b1;
                end
            end

            if (state_q == S_IDLE && elig_c != 2'b00) begin
                sel_q       <= sel_c;
                last_q      <= sel_c;
                dma_ack_q   <= sel_c ? 2'b10 : 2'b01;
                active_q    <= sel_c ? 2'b10 : 2'b01;
                burst_len_q <= 16'(blen_c);
                beats_q     <= BC_W'(blen_c);
            end

            if (state_q == S_BURST) begin
                if (err_hit_c) begin
                    busy_q[sel_q] <= 1'b0;
                    rem_q[sel_q]  <= '0;
                    err_q[sel_q]  <= 1'b1;
                end else if (ack_hit_c) begin
                    waddr_q[sel_q] <= waddr_q[sel_q] + WA_W'(1);
                    rem_q[sel_q]   <= rem_q[sel_q] - LEN_W'(1);
                    beats_q        <= beats_q - BC_W'(1);
                    if (rem_q[sel_q] == LEN_W'(1)) begin
                        busy_q[sel_q] <= 1'b0;
                        done_q[sel_q] <= 1'b1;
                    end
                end
            end

            // Sideband describes the burst in flight and is dropped on return to IDLE.
            if (state_q != S_IDLE && state_d == S_IDLE) begin
                active_q    <= '0;
                burst_len_q <= '0;
            end
        end
    end

    assign ch_busy   = busy_q;
    assign ch_done   = done_q;
    assign ch_err    = err_q;
    assign dma_ack   = dma_ack_q;
    assign active_ch = active_q;
    assign burst_len = burst_len_q;
    assign snk_data  = snk_data_q;
    assign snk_dv    = snk_dv_q;
    assign src_rd    = ack_hit_c & cur_we_c;

    assign wb.wb_adr_o  = {waddr_q[sel_q], 3'b000};
    assign wb.wb_dat_o  = src_data;
    assign wb.wb_cyc_o  = cyc_q;
    assign wb.wb_stb_o  = stb_c;
    assign wb.wb_we_o   = cyc_q & cur_we_c;
    assign wb.wb_lock_o = cyc_q;
    assign wb.wb_sel_o  = 8'hFF;
endmodule

// File: tb/tb_dma_wb_burst_master.sv
// Scoreboard bench: tests queue expected grants, beats, read data and completions;
// a Wishbone slave/monitor process pops and compares as the DUT presents them.
module tb_dma_wb_burst_master;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ch_start, ch_write, dma_req;
    logic [31:0] ch0_addr, ch1_addr;
    logic [15:0] ch0_len, ch1_len;
    logic [1:0]  ch_busy, ch_done, ch_err, dma_ack, active_ch;
    logic [15:0] burst_len;
    logic [63:0] src_data, snk_data;
    logic        src_valid, src_rd, snk_dv;

    dma_wb_burst_master_if #(.ADDR_W(32)) wb ();

    dma_wb_burst_master #(.ADDR_W(32), .LEN_W(16), .MAX_BURST(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .ch_start(ch_start), .ch_write(ch_write),
        .ch0_addr(ch0_addr), .ch1_addr(ch1_addr), .ch0_len(ch0_len), .ch1_len(ch1_len),
        .ch_busy(ch_busy), .ch_done(ch_done), .ch_err(ch_err),
        .dma_req(dma_req), .dma_ack(dma_ack), .active_ch(active_ch), .burst_len(burst_len),
        .wb(wb),
        .src_data(src_data), .src_valid(src_valid), .src_rd(src_rd),
        .snk_data(snk_data), .snk_dv(snk_dv)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [32:0] q_adr[$];
    logic [19:0] q_gnt[$];
    logic [3:0]  q_evt[$];
    logic [63:0] q_snk[$];

    int err_at = 0, rty_at = 0, attempt = 0, n_ack = 0, n_src = 0, cyc_cnt = 0, stb_bad = 0;
    int rty_phase = 0;
    bit err_chk = 0, cyc_seen = 0;
    logic [31:0] rty_adr;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic unexpected(input string nm, input logic [127:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected output %0h", nm, act);
    endtask

    function automatic logic [63:0] rdata(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    task automatic exp_beats(input bit we, input logic [31:0] a0, input int n);
        for (int k = 0; k < n; k++) begin
            q_adr.push_back({we, a0 + 32'(8 * k)});
            if (!we) q_snk.push_back(rdata(a0 + 32'(8 * k)));
        end
    endtask

    task automatic exp_gnt(input logic [1:0] ch, input int len);
        q_gnt.push_back({ch, ch, 16'(len)});
    endtask

    task automatic set_ch(input int ch, input bit wr, input logic [31:0] a, input logic [15:0] l);
        if (ch == 0) begin ch0_addr = a; ch0_len = l; end
        else         begin ch1_addr = a; ch1_len = l; end
        ch_write[ch] = wr;
    endtask

    task automatic pulse(input logic [1:0] m);
        @(negedge clk);
        ch_start = m;
        @(negedge clk);
        ch_start = 2'b00;
    endtask

    task automatic cfg(input int e, input int r);
        err_at = e; rty_at = r; attempt = 0; n_ack = 0; n_src = 0; cyc_seen = 0;
    endtask

    // Bounded wait for the scoreboard to drain and both channels to go idle.
    task automatic wait_done(input string nm, input int budget);
        int c;
        for (c = 0; c < budget; c++) begin
            @(negedge clk);
            #3;
            if (q_adr.size() == 0 && q_gnt.size() == 0 && q_evt.size() == 0 &&
                q_snk.size() == 0 && ch_busy == 2'b00) break;
        end
        chk({nm, "_beats_left"},  q_adr.size(), 0);
        chk({nm, "_grants_left"}, q_gnt.size(), 0);
        chk({nm, "_events_left"}, q_evt.size() + q_snk.size(), 0);
        chk({nm, "_busy"}, ch_busy, 2'b00);
    endtask

    // Wishbone slave plus output monitor; drives at negedge+1, samples at negedge+2.
    initial begin
        wb.wb_ack_i = 0; wb.wb_err_i = 0; wb.wb_rty_i = 0; wb.wb_dat_i = '0;
        src_valid = 0; src_data = '0;
        forever begin
            @(negedge clk);
            cyc_cnt++;
            src_valid = (cyc_cnt % 5) != 4;
            src_data  = {32'h5A5A_0000, 32'(cyc_cnt)};
            wb.wb_ack_i = 0; wb.wb_err_i = 0; wb.wb_rty_i = 0;
            #1;
            if (wb.wb_cyc_o) cyc_seen = 1;
            if (err_chk) begin chk("cyc_after_err", wb.wb_cyc_o, 1'b0); err_chk = 0; end
            if (rty_phase == 1) begin
                chk("cyc_rty_gap", wb.wb_cyc_o, 1'b0);
                rty_phase = 2;
            end else if (rty_phase == 2) begin
                chk("rty_reissue", {wb.wb_cyc_o, wb.wb_adr_o}, {1'b1, rty_adr});
                rty_phase = 0;
            end
            if (wb.wb_cyc_o && wb.wb_we_o && (wb.wb_stb_o !== src_valid)) stb_bad++;
            if (!rst && wb.wb_cyc_o && wb.wb_stb_o) begin
                attempt++;
                if (attempt == rty_at) begin
                    wb.wb_rty_i = 1; rty_adr = wb.wb_adr_o; rty_phase = 1;
                end else begin
                    if (attempt == err_at) begin wb.wb_err_i = 1; err_chk = 1; end
                    else begin wb.wb_ack_i = 1; n_ack++; end
                    wb.wb_dat_i = rdata(wb.wb_adr_o);
                    if (q_adr.size() == 0) unexpected("beat", {wb.wb_we_o, wb.wb_adr_o});
                    else chk("beat_we_adr", {wb.wb_we_o, wb.wb_adr_o}, q_adr.pop_front());
                end
            end
            #1;
            if (src_rd) n_src++;
            if (dma_ack != 2'b00) begin
                if (q_gnt.size() == 0) unexpected("grant", {dma_ack, active_ch, burst_len});
                else chk("grant_ack_ch_len", {dma_ack, active_ch, burst_len}, q_gnt.pop_front());
            end
            if ((ch_done | ch_err) != 2'b00) begin
                if (q_evt.size() == 0) unexpected("done_err", {ch_err, ch_done});
                else chk("done_err", {ch_err, ch_done}, q_evt.pop_front());
            end
            if (snk_dv) begin
                if (q_snk.size() == 0) unexpected("snk", snk_data);
                else chk("snk_data", snk_data, q_snk.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1; ch_start = 0; ch_write = 0; dma_req = 0;
        ch0_addr = 0; ch1_addr = 0; ch0_len = 0; ch1_len = 0;
        repeat (3) @(negedge clk);
        #3;
        chk("rst_outputs", {ch_busy, ch_done, ch_err, dma_ack, active_ch, burst_len},
            {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0});
        chk("rst_bus", {wb.wb_cyc_o, wb.wb_stb_o, wb.wb_adr_o, snk_dv}, '0);
        rst = 0;

        // ch0 write 0x1000 x40 -> bursts 16,16,8
        cfg(0, 0); dma_req = 2'b01;
        set_ch(0, 1, 32'h1000, 16'd40);
        exp_gnt(2'b01, 16); exp_gnt(2'b01, 16); exp_gnt(2'b01, 8);
        exp_beats(1, 32'h1000, 40);
        q_evt.push_back(4'b00_01);
        pulse(2'b01);
        wait_done("t1", 400);
        chk("t1_src_rd", n_src, 40);

        // ch1 read 0x1FC0 x16 -> split at 4KB into 8,8
        cfg(0, 0); dma_req = 2'b10;
        set_ch(1, 0, 32'h1FC0, 16'd16);
        exp_gnt(2'b10, 8); exp_gnt(2'b10, 8);
        exp_beats(0, 32'h1FC0, 16);
        q_evt.push_back(4'b00_10);
        pulse(2'b10);
        wait_done("t2", 200);
        chk("t2_acks", n_ack, 16);

        // both channels, round robin 01,10,01,10
        cfg(0, 0); dma_req = 2'b11;
        set_ch(0, 1, 32'h0000, 16'd32);
        set_ch(1, 0, 32'h8000, 16'd32);
        exp_gnt(2'b01, 16); exp_gnt(2'b10, 16); exp_gnt(2'b01, 16); exp_gnt(2'b10, 16);
        exp_beats(1, 32'h0000, 16); exp_beats(0, 32'h8000, 16);
        exp_beats(1, 32'h0080, 16); exp_beats(0, 32'h8080, 16);
        q_evt.push_back(4'b00_01); q_evt.push_back(4'b00_10);
        pulse(2'b11);
        wait_done("t3", 600);

        // bus error on 3rd beat of ch0
        cfg(3, 0); dma_req = 2'b01;
        set_ch(0, 1, 32'h3000, 16'd10);
        exp_gnt(2'b01, 10);
        exp_beats(1, 32'h3000, 3);
        q_evt.push_back(4'b01_00);
        pulse(2'b01);
        wait_done("t4", 200);
        chk("t4_acks", n_ack, 2);

        // zero-length descriptor
        cfg(0, 0);
        set_ch(0, 1, 32'h7000, 16'd0);
        q_evt.push_back(4'b00_01);
        pulse(2'b01);
        #3;
        chk("t5_done_next", {ch_done, ch_busy}, {2'b01, 2'b00});
        wait_done("t5", 20);
        chk("t5_cyc_seen", cyc_seen, 1'b0);

        // retry on attempt 5 of a ch1 write
        cfg(0, 5); dma_req = 2'b10;
        set_ch(1, 1, 32'h4000, 16'd8);
        exp_gnt(2'b10, 8);
        exp_beats(1, 32'h4000, 8);
        q_evt.push_back(4'b00_10);
        pulse(2'b10);
        wait_done("t6", 200);
        chk("t6_acks", n_ack, 8);
        chk("t6_src_rd", n_src, 8);

        // reset mid-burst, then a normal transfer
        cfg(0, 0); dma_req = 2'b01;
        set_ch(0, 1, 32'h5000, 16'd20);
        exp_gnt(2'b01, 16);
        exp_beats(1, 32'h5000, 16);
        pulse(2'b01);
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (n_ack >= 3) break;
        end
        chk("t7_reached_beats", n_ack >= 3, 1'b1);
        #3 rst = 1;
        #1;
        chk("t7_rst_async", {wb.wb_cyc_o, wb.wb_stb_o, dma_ack, ch_busy}, '0);
        q_adr.delete(); q_gnt.delete(); q_evt.delete(); q_snk.delete();
        rty_phase = 0; err_chk = 0;
        @(negedge clk);
        #3 rst = 0;
        cfg(0, 0);
        set_ch(0, 1, 32'h6000, 16'd4);
        exp_gnt(2'b01, 4);
        exp_beats(1, 32'h6000, 4);
        q_evt.push_back(4'b00_01);
        pulse(2'b01);
        wait_done("t7", 100);
        chk("t7_src_rd", n_src, 4);

        chk("stb_follows_src_valid", stb_bad, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
